// File: rtl/pong_pkg.sv
// Shared definitions for the pong game controller: FSM states, PS/2 scan codes,
// paddle command encodings and the score saturation helper.
package pong_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_POINT = 3'd3,
    ST_OVER  = 3'd4
  } state_t;

  // Paddle commands
  localparam logic [1:0] DIR_HOLD = 2'b00;
  localparam logic [1:0] DIR_UP   = 2'b01;
  localparam logic [1:0] DIR_DOWN = 2'b10;

  // PS/2 set-2 scan codes
  localparam logic [7:0] KEY_P1_UP = 8'h1D;  // W
  localparam logic [7:0] KEY_P1_DN = 8'h1B;  // S
  localparam logic [7:0] KEY_P2_UP = 8'h43;  // I
  localparam logic [7:0] KEY_P2_DN = 8'h42;  // K
  localparam logic [7:0] KEY_BREAK = 8'hF0;

  // Increment a score, never exceeding the winning limit
  function automatic logic [3:0] score_inc(input logic [3:0] s, input logic [3:0] lim);
    score_inc = (s >= lim) ? lim : s + 4'd1;
  endfunction

endpackage

// File: rtl/pong_key_decoder.sv
// PS/2 scan-code decoder producing paddle commands. The newest make code for a
// paddle wins; a break code only releases the paddle if it names the key that
// currently drives it.
module pong_key_decoder
  import pong_pkg::*;
(
  input  logic       vga_clk,
  input  logic       reset,
  input  logic       active,
  input  logic [7:0] key_code,
  input  logic       key_valid,
  output logic [1:0] p1_dir,
  output logic [1:0] p2_dir
);

  logic brk;

  // Break-flag tracking and paddle command registers
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      brk    <= 1'b0;
      p1_dir <= DIR_HOLD;
      p2_dir <= DIR_HOLD;
    end else begin
      if (key_valid) brk <= (key_code == KEY_BREAK);
      if (!active) begin
        p1_dir <= DIR_HOLD;
        p2_dir <= DIR_HOLD;
      end else if (key_valid && (key_code != KEY_BREAK)) begin
        if (brk) begin
          if ((key_code == KEY_P1_UP && p1_dir == DIR_UP) ||
              (key_code == KEY_P1_DN && p1_dir == DIR_DOWN))
            p1_dir <= DIR_HOLD;
          if ((key_code == KEY_P2_UP && p2_dir == DIR_UP) ||
              (key_code == KEY_P2_DN && p2_dir == DIR_DOWN))
            p2_dir <= DIR_HOLD;
        end else begin
          case (key_code)
            KEY_P1_UP: p1_dir <= DIR_UP;
            KEY_P1_DN: p1_dir <= DIR_DOWN;
            KEY_P2_UP: p2_dir <= DIR_UP;
            KEY_P2_DN: p2_dir <= DIR_DOWN;
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game controller: game-tick generator, serve delay, point scoring and
// game-over handling, plus keyboard-driven paddle commands.
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int TICK_DIV    = 400000,
  parameter int WIN_SCORE   = 9,
  parameter int SERVE_TICKS = 120
) (
  input  logic       vga_clk,
  input  logic       reset,
  input  logic       run,
  input  logic [7:0] key_code,
  input  logic       key_valid,
  input  logic       miss_left,
  input  logic       miss_right,
  output logic       tick,
  output logic       ball_en,
  output logic       ball_reset,
  output logic       serve_dir,
  output logic [1:0] p1_dir,
  output logic [1:0] p2_dir,
  output logic [3:0] p1_score,
  output logic [3:0] p2_score,
  output logic [2:0] state,
  output logic       game_over
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SERVE_TICKS > 1) ? $clog2(SERVE_TICKS) : 1;
  localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SERVE_LAST = SW'(SERVE_TICKS - 1);
  localparam logic [3:0]    WIN        = 4'(WIN_SCORE);

  state_t        st, nxt;
  logic [TW-1:0] tick_cnt;
  logic [SW-1:0] serve_cnt;
  logic          rst_pend;   // first IDLE edge after reset still owes a ball_reset
  logic          p2_pt;      // last point went to player 2
  logic          tick_evt, hit, nxt_active, cnt_run;
  logic [3:0]    p1_new, p2_new;

  assign tick_evt   = (tick_cnt == TICK_LAST);
  assign hit        = miss_left | miss_right;
  assign p1_new     = score_inc(p1_score, WIN);
  assign p2_new     = score_inc(p2_score, WIN);
  assign nxt_active = (nxt == ST_SERVE) || (nxt == ST_PLAY);
  assign cnt_run    = nxt_active && ((st == ST_SERVE) || (st == ST_PLAY));
  assign state      = st;

  // Next-state selection; run=0 overrides everything
  always_comb begin
    nxt = st;
    if (!run) begin
      nxt = ST_IDLE;
    end else begin
      case (st)
        ST_IDLE:  nxt = ST_SERVE;
        ST_SERVE: if (tick_evt && serve_cnt == SERVE_LAST) nxt = ST_PLAY;
        ST_PLAY:  if (hit) nxt = ST_POINT;
        ST_POINT: nxt = (((p2_pt ? p2_new : p1_new)) == WIN) ? ST_OVER : ST_SERVE;
        ST_OVER:  nxt = ST_OVER;
        default:  nxt = ST_IDLE;
      endcase
    end
  end

  // FSM state, counters, scores and registered outputs
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      st         <= ST_IDLE;
      tick_cnt   <= '0;
      serve_cnt  <= '0;
      tick       <= 1'b0;
      ball_en    <= 1'b0;
      ball_reset <= 1'b0;
      serve_dir  <= 1'b0;
      p1_score   <= 4'd0;
      p2_score   <= 4'd0;
      game_over  <= 1'b0;
      rst_pend   <= 1'b1;
      p2_pt      <= 1'b0;
    end else begin
      st         <= nxt;
      ball_en    <= (nxt == ST_PLAY);
      game_over  <= (nxt == ST_OVER);
      ball_reset <= 1'b0;

      if (cnt_run) begin
        tick_cnt <= tick_evt ? '0 : tick_cnt + 1'b1;
        tick     <= tick_evt;
      end else begin
        tick_cnt <= '0;
        tick     <= 1'b0;
      end

      if (st == ST_SERVE && nxt == ST_SERVE) begin
        if (tick_evt) serve_cnt <= serve_cnt + 1'b1;
      end else begin
        serve_cnt <= '0;
      end

      if (st == ST_PLAY && nxt == ST_POINT) p2_pt <= miss_left;

      if (st == ST_IDLE) begin
        ball_reset <= rst_pend;
        rst_pend   <= 1'b0;
      end else if (nxt == ST_IDLE) begin
        ball_reset <= 1'b1;
        p1_score   <= 4'd0;
        p2_score   <= 4'd0;
      end else if (st == ST_POINT) begin
        if (p2_pt) p2_score <= p2_new;
        else       p1_score <= p1_new;
        serve_dir <= ~p2_pt;
        if (nxt == ST_SERVE) ball_reset <= 1'b1;
      end
    end
  end

  pong_key_decoder u_keys (
    .vga_clk  (vga_clk),
    .reset    (reset),
    .active   (nxt_active),
    .key_code (key_code),
    .key_valid(key_valid),
    .p1_dir   (p1_dir),
    .p2_dir   (p2_dir)
  );

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl with a short tick divider and serve delay.
module tb_pong_game_ctrl;

  logic       vga_clk = 1'b0;
  logic       reset, run, key_valid, miss_left, miss_right;
  logic [7:0] key_code;
  logic       tick, ball_en, ball_reset, serve_dir, game_over;
  logic [1:0] p1_dir, p2_dir;
  logic [3:0] p1_score, p2_score;
  logic [2:0] state;

  int n_chk  = 0;
  int n_fail = 0;

  localparam logic [2:0] S_IDLE = 3'd0, S_SERVE = 3'd1, S_PLAY = 3'd2, S_POINT = 3'd3, S_OVER = 3'd4;

  pong_game_ctrl #(.TICK_DIV(4), .WIN_SCORE(3), .SERVE_TICKS(3)) dut (
    .vga_clk   (vga_clk),
    .reset     (reset),
    .run       (run),
    .key_code  (key_code),
    .key_valid (key_valid),
    .miss_left (miss_left),
    .miss_right(miss_right),
    .tick      (tick),
    .ball_en   (ball_en),
    .ball_reset(ball_reset),
    .serve_dir (serve_dir),
    .p1_dir    (p1_dir),
    .p2_dir    (p2_dir),
    .p1_score  (p1_score),
    .p2_score  (p2_score),
    .state     (state),
    .game_over (game_over)
  );

  always #5 vga_clk = ~vga_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge vga_clk);
  endtask

  task automatic send_key(input logic [7:0] code);
    key_code  = code;
    key_valid = 1'b1;
    cyc();
    key_valid = 1'b0;
  endtask

  task automatic wait_state(input logic [2:0] s, input string tag);
    int i;
    i = 0;
    while (state !== s && i < 40) begin
      cyc();
      i++;
    end
    chk(tag, state, s);
  endtask

  // miss pulse in PLAY followed by the POINT cycle
  task automatic score_point(input logic ml, input logic mr);
    miss_left  = ml;
    miss_right = mr;
    cyc();
    miss_left  = 1'b0;
    miss_right = 1'b0;
    chk("point_state", state, S_POINT);
    cyc();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; run = 1'b0; key_valid = 1'b0; key_code = 8'h00;
    miss_left = 1'b0; miss_right = 1'b0;
    cyc(); cyc();
    chk("rst_state", state, S_IDLE);
    chk("rst_ball_reset", ball_reset, 0);
    chk("rst_tick", tick, 0);
    chk("rst_scores", {p1_score, p2_score}, 0);
    reset = 1'b0;
    cyc();
    chk("first_idle_ball_reset", ball_reset, 1);
    cyc();
    chk("ball_reset_width", ball_reset, 0);
    chk("idle_hold", state, S_IDLE);

    // Serve: tick every 4 cycles, PLAY on the third tick
    run = 1'b1;
    cyc();
    chk("serve_entry", state, S_SERVE);
    chk("serve_ball_en", ball_en, 0);
    for (int k = 1; k <= 12; k++) begin
      cyc();
      chk($sformatf("tick_k%0d", k), tick, (k % 4 == 0) ? 1 : 0);
      chk($sformatf("state_k%0d", k), state, (k < 12) ? S_SERVE : S_PLAY);
    end
    chk("play_ball_en", ball_en, 1);

    // Keyboard decoding in PLAY
    send_key(8'h1D); chk("p1_up", p1_dir, 2'b01);
    send_key(8'hF0); chk("p1_break_armed", p1_dir, 2'b01);
    send_key(8'h1D); chk("p1_release", p1_dir, 2'b00);
    send_key(8'h43); chk("p2_up", p2_dir, 2'b01);
    send_key(8'h42); chk("p2_down", p2_dir, 2'b10);
    send_key(8'h55); chk("unknown_p2", p2_dir, 2'b10);
    chk("unknown_p1", p1_dir, 2'b00);
    send_key(8'h1D); send_key(8'h1B);
    chk("p1_newest", p1_dir, 2'b10);
    send_key(8'hF0); send_key(8'h1D);
    chk("p1_stale_break", p1_dir, 2'b10);
    chk("still_play", state, S_PLAY);

    // Point to player 1
    miss_right = 1'b1;
    cyc();
    miss_right = 1'b0;
    chk("pt_state", state, S_POINT);
    chk("pt_ball_en", ball_en, 0);
    chk("pt_dir_hold", p1_dir, 2'b00);
    cyc();
    chk("pt_p1", p1_score, 1);
    chk("pt_serve_dir", serve_dir, 1);
    chk("pt_ball_reset", ball_reset, 1);
    chk("pt_back_serve", state, S_SERVE);

    // Misses outside PLAY are ignored
    miss_left = 1'b1;
    cyc();
    miss_left = 1'b0;
    chk("ign_state", state, S_SERVE);
    chk("ign_ball_reset", ball_reset, 0);
    cyc();
    chk("ign_p2", p2_score, 0);

    // Simultaneous misses score player 2 only
    wait_state(S_PLAY, "reach_play1");
    score_point(1'b1, 1'b1);
    chk("both_p2", p2_score, 1);
    chk("both_p1", p1_score, 1);
    chk("both_serve_dir", serve_dir, 0);
    chk("both_state", state, S_SERVE);

    // Player 2 to winning score
    wait_state(S_PLAY, "reach_play2");
    score_point(1'b1, 1'b0);
    chk("p2_two", p2_score, 2);
    chk("p2_two_state", state, S_SERVE);
    wait_state(S_PLAY, "reach_play3");
    score_point(1'b1, 1'b0);
    chk("win_p2", p2_score, 3);
    chk("win_state", state, S_OVER);
    chk("win_game_over", game_over, 1);
    chk("win_ball_en", ball_en, 0);
    chk("win_no_ball_reset", ball_reset, 0);
    miss_left = 1'b1;
    cyc();
    miss_left = 1'b0;
    cyc();
    chk("over_frozen_p2", p2_score, 3);
    chk("over_stays", state, S_OVER);

    // run=0 leaves OVER
    run = 1'b0;
    cyc();
    chk("stop_state", state, S_IDLE);
    chk("stop_scores", {p1_score, p2_score}, 0);
    chk("stop_ball_reset", ball_reset, 1);
    chk("stop_game_over", game_over, 0);
    cyc();
    chk("stop_ball_reset_width", ball_reset, 0);

    // New game, p1 reaches 2, then asynchronous reset mid-PLAY
    run = 1'b1;
    wait_state(S_PLAY, "reach_play4");
    score_point(1'b0, 1'b1);
    wait_state(S_PLAY, "reach_play5");
    score_point(1'b0, 1'b1);
    chk("p1_two", p1_score, 2);
    wait_state(S_PLAY, "reach_play6");
    send_key(8'h1D);
    chk("pre_rst_p1_dir", p1_dir, 2'b01);
    #2 reset = 1'b1;
    #1;
    chk("arst_state", state, S_IDLE);
    chk("arst_scores", {p1_score, p2_score}, 0);
    chk("arst_ctl", {tick, ball_en, ball_reset, serve_dir, game_over}, 0);
    chk("arst_dirs", {p1_dir, p2_dir}, 0);
    cyc();
    reset = 1'b0;
    run = 1'b0;
    cyc();
    chk("post_rst_ball_reset", ball_reset, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
